// File: rtl/cond_sel_pipe.sv
// Two-stage conditional channel-select pipeline with SEL/SUM/CMP/REP operations,
// a programmable default register and a saturating CMP match counter.
module cond_sel_pipe #(
  parameter  int DW   = 16,
  parameter  int NCH  = 4,
  parameter  int CNTW = 16,
  localparam int SW   = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_mode,
  input  logic [SW-1:0]     in_sela,
  input  logic [SW-1:0]     in_selb,
  input  logic [NCH*DW-1:0] in_data,
  input  logic              def_we,
  input  logic [DW-1:0]     def_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_data,
  output logic              out_flag,
  output logic [CNTW-1:0]   match_cnt,
  input  logic              cnt_clr
);

  typedef enum logic [1:0] {
    MODE_SEL = 2'd0,
    MODE_SUM = 2'd1,
    MODE_CMP = 2'd2,
    MODE_REP = 2'd3
  } mode_e;

  logic [DW-1:0]   def_q, def_d;

  logic            s1_valid_q, s1_valid_d;
  mode_e           s1_mode_q, s1_mode_d;
  logic [DW-1:0]   s1_a_q, s1_a_d;
  logic [DW-1:0]   s1_b_q, s1_b_d;
  logic [DW-1:0]   s1_def_q, s1_def_d;

  logic            s2_valid_q, s2_valid_d;
  logic [DW-1:0]   s2_data_q, s2_data_d;
  logic            s2_flag_q, s2_flag_d;
  logic            s2_cmp_q, s2_cmp_d;

  logic [CNTW-1:0] cnt_q, cnt_d;

  logic [DW-1:0]   ch [NCH];
  logic            s2_can_load;
  logic            accept;
  logic            handoff;
  logic [DW:0]     sum;
  logic [DW-1:0]   res_data;
  logic            res_flag;
  logic            res_cmp;

  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      ch[k] = in_data[k*DW +: DW];
    end
  end

  // S2 frees up whenever it is empty or its result is being taken this cycle.
  assign s2_can_load = !s2_valid_q || out_ready;
  assign in_ready    = !s1_valid_q || s2_can_load;
  assign accept      = in_valid && in_ready;
  assign handoff     = s2_valid_q && out_ready;

  always_comb begin
    def_d = def_q;
    if (def_we) begin
      def_d = def_data;
    end
  end

  // S1 captures the old default value, so a same-cycle def_we is not seen here.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_mode_d  = s1_mode_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_def_d   = s1_def_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_mode_d  = mode_e'(in_mode);
      s1_a_d     = ch[in_sela];
      s1_b_d     = ch[in_selb];
      s1_def_d   = def_q;
    end else if (s2_can_load) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    sum      = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    res_data = s1_a_q;
    res_flag = 1'b0;
    res_cmp  = 1'b0;
    case (s1_mode_q)
      MODE_SEL: begin
        res_data = s1_a_q;
      end
      MODE_SUM: begin
        res_data = sum[DW] ? {DW{1'b1}} : sum[DW-1:0];
        res_flag = sum[DW];
      end
      MODE_CMP: begin
        res_cmp = 1'b1;
        if (s1_a_q == s1_b_q) begin
          res_data = {DW{1'b1}};
          res_flag = 1'b1;
        end else begin
          res_data = s1_def_q;
        end
      end
      MODE_REP: begin
        res_data = {DW{s1_a_q[0]}};
      end
      default: begin
        res_data = s1_a_q;
      end
    endcase
  end

  // Output register only changes when S2 may load, which keeps a stalled result stable.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_flag_d  = s2_flag_q;
    s2_cmp_d   = s2_cmp_q;
    if (s2_can_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = res_data;
        s2_flag_d = res_flag;
        s2_cmp_d  = res_cmp;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (handoff && s2_cmp_q && s2_flag_q && (cnt_q != {CNTW{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      def_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_mode_q  <= MODE_SEL;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_def_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_flag_q  <= 1'b0;
      s2_cmp_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      def_q      <= def_d;
      s1_valid_q <= s1_valid_d;
      s1_mode_q  <= s1_mode_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_def_q   <= s1_def_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_flag_q  <= s2_flag_d;
      s2_cmp_q   <= s2_cmp_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_flag  = s2_flag_q;
  assign match_cnt = cnt_q;

endmodule
